// File: rtl/rr_pkg.sv
// -----------------------------------------------------------------------------
// rr_pkg
// Shared types and constants for the register-read hazard scoreboard.
//   fwd_sel_t      : operand source selection driven to the rr operand muxes
//   LAT_*          : latency classes carried with each issued instruction
//   WB_AGE_DEFAULT : age at which a producer sits in wb
//   AGE_W_DEFAULT  : width of the per-register age counter
// -----------------------------------------------------------------------------
package rr_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'd0,
    FWD_EX  = 2'd1,
    FWD_MEM = 2'd2,
    FWD_WB  = 2'd3
  } fwd_sel_t;

  localparam logic [1:0] LAT_NONE = 2'd0;
  localparam logic [1:0] LAT_ALU  = 2'd1;
  localparam logic [1:0] LAT_LOAD = 2'd2;

  localparam int WB_AGE_DEFAULT = 3;
  localparam int AGE_W_DEFAULT  = 2;

  // The reserved latency code 3 behaves like a load.
  function automatic logic [1:0] norm_lat(input logic [1:0] lat);
    return (lat == 2'd3) ? LAT_LOAD : lat;
  endfunction

endpackage

// File: rtl/scoreboard_entry.sv
// -----------------------------------------------------------------------------
// scoreboard_entry
// Tracks one architectural register's in-flight producer.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   advance_i    : pipeline moves this cycle (low = downstream freeze)
//   set_i        : a new producer for this register is accepted this cycle
//   set_lat_i    : latency class of the new producer
//   busy_o       : a producer is in flight
//   age_o        : stages travelled since rr (1=EX, 2=MEM, 3=WB)
//   ready_o      : result is forwardable (age >= latency)
// -----------------------------------------------------------------------------
module scoreboard_entry
  import rr_pkg::*;
#(
  parameter int AGE_W  = AGE_W_DEFAULT,
  parameter int WB_AGE = WB_AGE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance_i,
  input  logic             set_i,
  input  logic [1:0]       set_lat_i,
  output logic             busy_o,
  output logic [AGE_W-1:0] age_o,
  output logic             ready_o
);

  logic             busy_q, busy_d;
  logic [AGE_W-1:0] age_q, age_d;
  logic [1:0]       lat_q, lat_d;

  // A new producer enters ex on the same edge it is accepted, so it starts at
  // age 1. It overrides any older producer, including one retiring this edge.
  always_comb begin
    busy_d = busy_q;
    age_d  = age_q;
    lat_d  = lat_q;
    if (advance_i) begin
      if (set_i) begin
        busy_d = 1'b1;
        age_d  = AGE_W'(1);
        lat_d  = norm_lat(set_lat_i);
      end else if (busy_q) begin
        if (age_q == AGE_W'(WB_AGE)) begin
          busy_d = 1'b0;
          age_d  = '0;
          lat_d  = LAT_NONE;
        end else begin
          age_d = age_q + AGE_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      age_q  <= '0;
      lat_q  <= LAT_NONE;
    end else begin
      busy_q <= busy_d;
      age_q  <= age_d;
      lat_q  <= lat_d;
    end
  end

  assign busy_o  = busy_q;
  assign age_o   = age_q;
  assign ready_o = int'(age_q) >= int'(lat_q);

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Operand hazard scoreboard for the rr stage of the rr -> ex -> mem -> wb
// pipeline. Decides whether the rr instruction issues or stalls and picks the
// forwarding source of each operand.
// Ports:
//   clk, reset                    : clock, asynchronous active-low reset
//   i_issue_valid/rd/lat          : rr instruction and its destination/latency
//   i_rs1_number/used, i_rs2_*    : rr source operands
//   i_pipeline_stall              : downstream freeze
//   i_load_new_pc                 : redirect, kills the rr instruction
//   o_stall                       : hold rr
//   o_rs1_fwd_sel, o_rs2_fwd_sel  : 0=regfile 1=EX 2=MEM 3=WB
//   o_busy_count                  : number of in-flight producers
// -----------------------------------------------------------------------------
module hazard_scoreboard
  import rr_pkg::*;
#(
  parameter int AGE_W  = AGE_W_DEFAULT,
  parameter int WB_AGE = WB_AGE_DEFAULT,
  parameter int NREG   = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_issue_valid,
  input  logic [4:0] i_issue_rd,
  input  logic [1:0] i_issue_lat,
  input  logic [4:0] i_rs1_number,
  input  logic [4:0] i_rs2_number,
  input  logic       i_rs1_used,
  input  logic       i_rs2_used,
  input  logic       i_pipeline_stall,
  input  logic       i_load_new_pc,
  output logic       o_stall,
  output logic [1:0] o_rs1_fwd_sel,
  output logic [1:0] o_rs2_fwd_sel,
  output logic [5:0] o_busy_count
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] ready;
  logic [AGE_W-1:0] age [NREG];

  logic     accept;
  logic     hazard;
  logic     rs1_hazard, rs2_hazard;
  fwd_sel_t rs1_fwd, rs2_fwd;

  // x0 is never a producer, so slot 0 is tied off.
  assign busy[0]  = 1'b0;
  assign ready[0] = 1'b0;
  assign age[0]   = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_entry
    scoreboard_entry #(
      .AGE_W (AGE_W),
      .WB_AGE(WB_AGE)
    ) u_entry (
      .clk      (clk),
      .rst_n    (reset),
      .advance_i(!i_pipeline_stall),
      .set_i    (accept && (i_issue_rd == 5'(r))),
      .set_lat_i(i_issue_lat),
      .busy_o   (busy[r]),
      .age_o    (age[r]),
      .ready_o  (ready[r])
    );
  end

  // An operand whose producer is not yet forwardable is a hazard and reads
  // the regfile selection; otherwise the producer's age names its stage.
  always_comb begin
    rs1_hazard = 1'b0;
    rs1_fwd    = FWD_RF;
    if (i_rs1_used && (i_rs1_number != 5'd0) && busy[i_rs1_number]) begin
      if (ready[i_rs1_number]) rs1_fwd = fwd_sel_t'(2'(age[i_rs1_number]));
      else                     rs1_hazard = 1'b1;
    end
  end

  always_comb begin
    rs2_hazard = 1'b0;
    rs2_fwd    = FWD_RF;
    if (i_rs2_used && (i_rs2_number != 5'd0) && busy[i_rs2_number]) begin
      if (ready[i_rs2_number]) rs2_fwd = fwd_sel_t'(2'(age[i_rs2_number]));
      else                     rs2_hazard = 1'b1;
    end
  end

  // A redirect kills the rr instruction, so there is nothing to hold.
  always_comb begin
    hazard  = i_issue_valid && (rs1_hazard || rs2_hazard);
    o_stall = !i_load_new_pc && (hazard || i_pipeline_stall);
    accept  = i_issue_valid && !o_stall && !i_load_new_pc &&
              (i_issue_rd != 5'd0) && (i_issue_lat != LAT_NONE);
  end

  always_comb begin
    o_busy_count = '0;
    for (int r = 0; r < NREG; r++) begin
      o_busy_count = o_busy_count + 6'(busy[r]);
    end
  end

  assign o_rs1_fwd_sel = rs1_fwd;
  assign o_rs2_fwd_sel = rs2_fwd;

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Per-register scoreboard that sequences operand hazards for the register-read stage of the in-order rr -> ex -> mem -> wb pipeline. It tracks every in-flight destination register by age and latency class. Each cycle it decides whether the instruction in rr may issue, or must stall, and for each source operand selects regfile, EX, MEM or WB forwarding. It replaces ad-hoc rd-number compares in rr, and its stall output feeds id/rr.

Parameters:
AGE_W, 2, width of per-entry age counter
WB_AGE, 3, age at which producer sits in wb; entry retires on next advance
NREG, 32, architectural registers tracked (x0 never tracked)

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
i_issue_valid  in  1  valid instruction present in rr
i_issue_rd  in  5  destination register of rr instruction
i_issue_lat  in  2  age at which result becomes forwardable: 1=ALU (EX), 2=load (MEM); 0 = no writeback, 3 reserved, treat as 2
i_rs1_number  in  5  rr source 1
i_rs2_number  in  5  rr source 2
i_rs1_used  in  1  source 1 actually read
i_rs2_used  in  1  source 2 actually read
i_pipeline_stall  in  1  downstream freeze from ex
i_load_new_pc  in  1  redirect; kills the rr instruction this cycle
o_stall  out  1  to id/rr: hold rr, do not issue
o_rs1_fwd_sel  out  2  0=regfile,1=EX,2=MEM,3=WB
o_rs2_fwd_sel  out  2  same encoding
o_busy_count  out  6  number of busy entries (debug/verification)

Behaviour:
- State per register r (1..31): busy, age[AGE_W-1:0], lat[1:0]. Registered; all other outputs combinational from state and inputs.
- Reset (reset=0, async): all busy=0, age=0, lat=0, so o_stall=0, fwd_sel=0 and o_busy_count=0 while low and after release.
- Source check for rsN with rsN_used=1, rsN!=0, entry busy:
  - age < lat: hazard.
  - Otherwise fwd_sel = age (1=EX, 2=MEM, 3=WB).
- Unused source, x0, or non-busy entry: fwd_sel=0.
- Hazard output and stall:
  - hazard = i_issue_valid & (rs1 hazard | rs2 hazard).
  - o_stall = hazard | i_pipeline_stall.
  - o_stall is forced 0 when i_load_new_pc=1.
  - fwd_sel is still driven during a stall.
- Accept condition: accept = i_issue_valid & !o_stall & !i_load_new_pc & i_issue_rd!=0 & i_issue_lat!=0.
- Advance rule (posedge):
  - If i_pipeline_stall=1: no entry changes, no accept (freeze).
  - Else every busy entry increments age. An entry with age==WB_AGE clears busy (regfile written end of wb).
  - A hazard stall without downstream stall still advances; the bubble goes downstream.
- Accept writes entry[rd]: busy=1, age=0 (age 0 becomes 1 at the same edge the instruction enters ex, i.e. write age=1 at the accept edge), lat=i_issue_lat.
- WAW: an accept to a busy rd overwrites it; the newest producer wins and the older entry is discarded.
- Same-cycle read/write of the same register: source checks use pre-edge state, so an instruction never depends on itself.
- A same-cycle retire and accept to the same rd leaves the accept result.
- i_load_new_pc: suppresses the accept; existing entries still advance normally (they are older than the redirecting branch).
- o_busy_count is the popcount of busy bits, with range 0..31.

Decomposition:
- Package rr_pkg:
  - fwd_sel_t enum (FWD_RF=0, FWD_EX=1, FWD_MEM=2, FWD_WB=3).
  - LAT_NONE=0, LAT_ALU=1, LAT_LOAD=2.
  - WB_AGE default.
- Sub-module scoreboard_entry, instantiated 31 times. It holds busy/age/lat, takes advance, set and set_lat, and outputs busy, age and ready (age>=lat).
- The top level holds the source muxes, hazard/stall logic and popcount.

Test Plan:
- Reset: hold reset=0 mid-run with 3 busy entries -> o_busy_count=0, o_stall=0, both fwd_sel=0 immediately; remains so after release.
- ALU chain: accept rd=5 lat=1; next 3 cycles rs1=5 -> stall=0, fwd_sel 1,2,3; 4th cycle fwd_sel=0, busy_count=0.
- Load-use: accept rd=7 lat=2; next cycle rs2=7 -> o_stall=1 for exactly 1 cycle. The following cycle gives stall=0 and rs2_fwd_sel=2.
- Freeze: accept rd=3 lat=2, then i_pipeline_stall=1 for 3 cycles -> o_stall=1, age frozen at 1. After release, a reader of x3 stalls 1 more cycle, then gets fwd_sel=2.
- WAW/x0: accept rd=4 lat=2, then rd=4 lat=1 -> reader of x4 next cycle gets EX, no stall. Accept rd=0 -> busy_count unchanged.
- Flush: i_issue_valid=1, rd=9, i_load_new_pc=1 -> o_stall=0, no entry created. A reader of x9 next cycle gets fwd_sel=0.
